soc_int_arbiter: RTL and testbench
==================================

SOC_INT_ARBITER -- requirements
Module: soc_int_arbiter

Interface
REQ-001 SHALL have parameter NUM_INTS, default 32, number of interrupt sources (legal range 2..32).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, max cycles irq is held awaiting ack; 0 disables timeout.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pending  input  NUM_INTS  asserted-and-enabled interrupt flags from the SoC interrupt controller.
REQ-006 SHALL have port int_clear  output  NUM_INTS  one-cycle one-hot clear pulse back to the flag register.
REQ-007 SHALL have port irq  output  1  interrupt request to core.
REQ-008 SHALL have port irq_id  output  $clog2(NUM_INTS)  index of requested source, valid while irq=1.
REQ-009 SHALL have port irq_ack  input  1  core accepts current request.
REQ-010 SHALL have port irq_done  input  1  core finished servicing (end of interrupt).
REQ-011 SHALL have port busy  output  1  high while in SERVICE.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on ack timeout.

Function
REQ-013 SHALL implement states IDLE, REQUEST, SERVICE; all outputs registered.
REQ-014 IDLE: when any pending bit is 1 at edge N, SHALL latch winner into irq_id and enter REQUEST, irq=1 from cycle N+1 (1-cycle latency).
REQ-015 Winner selection (fixed mode) SHALL be lowest set index of pending.
REQ-016 REQUEST: irq=1 and irq_id SHALL stay stable until state exits.
REQ-017 REQUEST with irq_ack=1 at an edge SHALL enter SERVICE, drive int_clear one-hot at irq_id for exactly the next cycle, irq=0, busy=1.
REQ-018 REQUEST with irq_ack=0 and pending[irq_id]=0 (source withdrawn) SHALL return to IDLE, irq=0, no int_clear, no timeout.
REQ-019 REQUEST cycle counter SHALL start at 0 on entry; if ACK_TIMEOUT>0 and counter reaches ACK_TIMEOUT without ack, SHALL return to IDLE, irq=0, timeout=1 for one cycle, no int_clear.
REQ-020 Priority within REQUEST at one edge: irq_ack > withdraw > timeout.
REQ-021 SERVICE: new pending bits SHALL be ignored (no nesting); irq_done=1 SHALL return to IDLE, busy=0 next cycle.
REQ-022 irq_ack outside REQUEST and irq_done outside SERVICE SHALL be ignored.
REQ-023 Each return to IDLE SHALL spend at least one cycle in IDLE before irq reasserts.
REQ-024 int_clear SHALL be zero in every cycle except the one following an accepted ack.

Reset
REQ-025 res SHALL override all inputs: state IDLE, irq=0, irq_id=0, int_clear=0, busy=0, timeout=0, counter=0, round-robin pointer=0.
REQ-026 Reset asserted in REQUEST or SERVICE SHALL abort without any int_clear or timeout pulse.

Configuration
REQ-027 Macro SOC_INT_ARB_RR_EN defined: SHALL select winner as first set pending bit searching upward from pointer with wrap; pointer = (irq_id+1) mod NUM_INTS after ack or timeout, unchanged on withdraw.
REQ-028 Macro SOC_INT_ARB_RR_EN undefined: SHALL use fixed lowest-index priority per REQ-015; no pointer register exists.

Verification
REQ-029 pending=0x0000_0014, ack 2 cycles after irq -> irq_id=2, int_clear=0x0000_0004 one cycle, busy=1 until irq_done.
REQ-030 ACK_TIMEOUT=4, irq raised, no ack -> irq drops after 4 REQUEST cycles, timeout pulse 1 cycle, int_clear stays 0.
REQ-031 pending=0x1 in REQUEST, pending drops to 0 without ack -> IDLE, irq=0, no int_clear, no timeout.
REQ-032 In SERVICE, pending=0x8 asserted -> irq stays 0 until irq_done; irq=1 with irq_id=3 two cycles after irq_done.
REQ-033 RR build, pending=0x0000_0005 held, ack+done each round -> irq_id sequence 0,2,0,2; fixed build -> 0,0,0,0.
REQ-034 res pulse while in REQUEST with irq_ack=1 same edge -> irq=0, int_clear=0, busy=0 next cycle.

Source files
------------

// File: rtl/soc_int_arbiter.sv
// soc_int_arbiter: picks one pending interrupt source, raises irq to the core,
// clears the source flag on ack and holds busy until end-of-interrupt.
// Optional round-robin selection is enabled by defining SOC_INT_ARB_RR_EN;
// without it the lowest pending index always wins.
module soc_int_arbiter #(
  parameter int unsigned NUM_INTS    = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic [NUM_INTS-1:0]         pending,
  output logic [NUM_INTS-1:0]         int_clear,
  output logic                        irq,
  output logic [$clog2(NUM_INTS)-1:0] irq_id,
  input  logic                        irq_ack,
  input  logic                        irq_done,
  output logic                        busy,
  output logic                        timeout
);

  localparam int unsigned ID_W    = $clog2(NUM_INTS);
  localparam int unsigned CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_INTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_SERVICE} state_t;

  state_t              r_state;
  logic                r_irq;
  logic [ID_W-1:0]     r_irq_id;
  logic [NUM_INTS-1:0] r_int_clear;
  logic                r_busy;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cnt;

  logic [ID_W-1:0]     w_winner;
  logic [NUM_INTS-1:0] w_onehot;
  logic                w_sel;
  logic                w_accept;
  logic                w_expire;

  assign irq       = r_irq;
  assign irq_id    = r_irq_id;
  assign int_clear = r_int_clear;
  assign busy      = r_busy;
  assign timeout   = r_timeout;

  // One-hot decode of the currently requested source
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_INTS; i++) begin
      w_onehot[i] = (r_irq_id == ID_W'(i));
    end
  end

  // Requested source still pending; ack wins, then withdraw, then timeout
  assign w_sel    = |(pending & w_onehot);
  assign w_accept = (r_state == ST_REQUEST) && irq_ack;
  assign w_expire = (r_state == ST_REQUEST) && !irq_ack && w_sel &&
                    (ACK_TIMEOUT > 0) && (r_cnt == CNT_W'(TO_LAST));

`ifdef SOC_INT_ARB_RR_EN
  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0]       r_ptr;
  logic [2*NUM_INTS-1:0] w_dbl;
  logic [NUM_INTS-1:0]   w_rot;
  logic [ID_W-1:0]       w_k;
  logic [SUM_W-1:0]      w_sum;

  // Rotate pending so the pointer sits at bit 0, then take the lowest set bit
  always_comb begin
    w_dbl = {pending, pending} >> r_ptr;
    w_rot = w_dbl[NUM_INTS-1:0];
    w_k   = '0;
    for (int i = NUM_INTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_k = ID_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_k};
    if (w_sum >= SUM_W'(NUM_INTS)) w_winner = ID_W'(w_sum - SUM_W'(NUM_INTS));
    else                           w_winner = ID_W'(w_sum);
  end

  // Pointer moves past the served source on ack or timeout, not on withdraw
  always_ff @(posedge clk) begin
    if (res) begin
      r_ptr <= '0;
    end else if (w_accept || w_expire) begin
      r_ptr <= (r_irq_id == LAST_ID) ? '0 : r_irq_id + ID_W'(1);
    end
  end
`else
  // Fixed priority: lowest pending index wins
  always_comb begin
    w_winner = '0;
    for (int i = NUM_INTS - 1; i >= 0; i--) begin
      if (pending[i]) w_winner = ID_W'(i);
    end
  end
`endif

  // Arbiter FSM with registered outputs; clear and timeout are single-cycle pulses
  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= ST_IDLE;
      r_irq       <= 1'b0;
      r_irq_id    <= '0;
      r_int_clear <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_int_clear <= '0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|pending) begin
            r_irq_id <= w_winner;
            r_irq    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (w_accept) begin
            r_irq       <= 1'b0;
            r_busy      <= 1'b1;
            r_int_clear <= w_onehot;
            r_state     <= ST_SERVICE;
          end else if (!w_sel) begin
            r_irq   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_irq     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SERVICE: begin
          if (irq_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_int_arbiter.sv
// Bench for soc_int_arbiter: table of per-cycle stimulus with expected outputs,
// plus a round-robin/fixed priority sequence depending on SOC_INT_ARB_RR_EN.
module tb_soc_int_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic [N-1:0]  pending = '0;
  logic          irq_ack = 1'b0;
  logic          irq_done = 1'b0;
  logic [N-1:0]  int_clear;
  logic          irq;
  logic [4:0]    irq_id;
  logic          busy;
  logic          timeout;

  soc_int_arbiter #(.NUM_INTS(N), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .res(res), .pending(pending), .int_clear(int_clear),
    .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        res;
    logic [31:0] pend;
    logic        ack;
    logic        done;
    logic        e_irq;
    logic [4:0]  e_id;
    logic [31:0] e_clr;
    logic        e_busy;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic a, input logic d,
                              input logic ei, input logic [4:0] eid, input logic [31:0] ec,
                              input logic eb, input logic et);
    vec_t v;
    v.res = r; v.pend = p; v.ack = a; v.done = d;
    v.e_irq = ei; v.e_id = eid; v.e_clr = ec; v.e_busy = eb; v.e_to = et;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    res = v.res; pending = v.pend; irq_ack = v.ack; irq_done = v.done;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (irq !== e.e_irq) begin
      failures++; $display("FAIL step%0d irq: got %b want %b", step_no, irq, e.e_irq);
    end
    if (e.e_irq || e.res) begin
      checks++;
      if (irq_id !== e.e_id) begin
        failures++; $display("FAIL step%0d irq_id: got %0d want %0d", step_no, irq_id, e.e_id);
      end
    end
    checks++;
    if (int_clear !== e.e_clr) begin
      failures++; $display("FAIL step%0d int_clear: got %h want %h", step_no, int_clear, e.e_clr);
    end
    checks++;
    if (busy !== e.e_busy) begin
      failures++; $display("FAIL step%0d busy: got %b want %b", step_no, busy, e.e_busy);
    end
    checks++;
    if (timeout !== e.e_to) begin
      failures++; $display("FAIL step%0d timeout: got %b want %b", step_no, timeout, e.e_to);
    end
    step_no++;
  endtask

  initial begin
    logic [4:0] rr_id;
    //                res pend          ack dn  irq id  clr           bsy to
    // reset, then pending 0x14 -> id 2, ack two cycles later, service, done
    vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0014, 0, 0, 1,  2, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0014, 0, 0, 1,  2, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0014, 1, 0, 0,  2, 32'h0000_0004, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 0, 0, 0,  2, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 0, 1, 0,  2, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 0, 0, 1,  4, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0010, 1, 0, 0,  4, 32'h0000_0010, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  4, 32'h0000_0000, 0, 0));
    // timeout after 4 REQUEST cycles, then one IDLE cycle before re-request
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 1,  7, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 1,  7, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 1,  7, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 1,  7, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 0,  7, 32'h0000_0000, 0, 1));
    vecs.push_back(mk(0, 32'h0000_0080, 0, 0, 1,  7, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  7, 32'h0000_0000, 0, 0));
    // withdraw of source 0, then stray ack/done ignored
    vecs.push_back(mk(0, 32'h0000_0001, 0, 0, 1,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 1, 0, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  0, 32'h0000_0000, 0, 0));
    // ack beats withdraw on the same edge
    vecs.push_back(mk(0, 32'h0000_0001, 0, 0, 1,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 1, 0, 0,  0, 32'h0000_0001, 1, 0));
    // no nesting: pending 0x8 during SERVICE waits for done
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 0,  0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 0,  0, 32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 1, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    // withdraw beats timeout on the expiry edge
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  3, 32'h0000_0000, 0, 0));
    // ack beats timeout on the expiry edge
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 0, 0, 1,  3, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0008, 1, 0, 0,  3, 32'h0000_0008, 1, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 1, 0,  3, 32'h0000_0000, 0, 0));
    // top index, reset with ack on the same edge aborts cleanly
    vecs.push_back(mk(0, 32'h8000_0000, 0, 0, 1, 31, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h8000_0000, 1, 0, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  0, 32'h0000_0000, 0, 0));
    // reset during SERVICE
    vecs.push_back(mk(0, 32'h0000_0002, 0, 0, 1,  1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0002, 1, 0, 0,  1, 32'h0000_0002, 1, 0));
    vecs.push_back(mk(1, 32'h0000_0002, 0, 0, 0,  0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 0,  0, 32'h0000_0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // pending 0x5 held across four ack/done rounds after a fresh reset
    step(mk(1, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
    for (int r = 0; r < 4; r++) begin
`ifdef SOC_INT_ARB_RR_EN
      rr_id = (r % 2 == 1) ? 5'd2 : 5'd0;
`else
      rr_id = 5'd0;
`endif
      step(mk(0, 32'h5, 0, 0, 1, rr_id, 32'h0, 0, 0));
      step(mk(0, 32'h5, 1, 0, 0, rr_id, 32'h1 << rr_id, 1, 0));
      step(mk(0, 32'h5, 0, 1, 0, rr_id, 32'h0, 0, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
